aes256_key_schedule: RTL and testbench

Sequential AES-256 key schedule generator. It captures a 256-bit cipher key and iterates the single-step 256-bit key expansion seven times, one step per clock. The fifteen 128-bit round keys go into an internal register file. It sits directly downstream of the combinational expansion step and upstream of the AES-256 round datapath, which reads round keys by index through a registered read port.

---
 rtl/aes_pkg.sv | 18 +
 rtl/Key_Expansion256.sv | 58 +++++
 rtl/aes256_key_schedule.sv | 126 ++++++++++++
 tb/tb_aes256_key_schedule.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, state encoding, GF(2^8) doubling.
package aes_pkg;

    localparam int NR256 = 14;
    localparam int NK256 = 8;

    typedef logic [127:0] round_key_t;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/Key_Expansion256.sv
// Combinational AES-256 expansion step: eight words in, next eight words out.
module Key_Expansion256
    import aes_pkg::*;
(
    input  logic [255:0] key_i,
    input  logic [31:0]  rcon_i,
    output logic [255:0] key_o
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as inverse (x^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w [0:7];
    logic [31:0] n [0:7];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = key_i[255-32*i -: 32];
        end
        n[0] = w[0] ^ subword({w[7][23:0], w[7][31:24]}) ^ rcon_i;
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        n[4] = w[4] ^ subword(n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];
        key_o = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    end

endmodule

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: seven expansion steps fill a 15-entry round-key file.
module aes256_key_schedule
    import aes_pkg::*;
#(
    parameter int NR   = NR256,
    parameter int KEYW = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KEYW-1:0] key_in,
    output logic            busy,
    output logic            done,
    output logic            valid,
    input  logic [3:0]      rd_addr,
    output round_key_t      rd_key
);

    localparam logic [2:0] LAST_STEP = 3'd6;

    ks_state_e       state_q, state_d;
    logic [KEYW-1:0] key_q, key_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      rc_q, rc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    round_key_t      rd_key_q;
    round_key_t      rk_q [0:NR];

    logic [KEYW-1:0] next_key;

    logic            wr_hi_en, wr_lo_en;
    logic [3:0]      wr_hi_idx, wr_lo_idx;
    round_key_t      wr_hi_data, wr_lo_data;

    Key_Expansion256 u_step (
        .key_i  (key_q),
        .rcon_i ({rc_q, 24'h0}),
        .key_o  (next_key)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        step_d     = step_q;
        rc_d       = rc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        wr_hi_en   = 1'b0;
        wr_lo_en   = 1'b0;
        wr_hi_idx  = 4'd0;
        wr_lo_idx  = 4'd1;
        wr_hi_data = '0;
        wr_lo_data = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_hi_en   = 1'b1;
                    wr_lo_en   = 1'b1;
                    wr_hi_data = key_in[KEYW-1:KEYW/2];
                    wr_lo_data = key_in[KEYW/2-1:0];
                    key_d      = key_in;
                    step_d     = 3'd0;
                    rc_d       = 8'h01;
                    valid_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = EXPAND;
                end
            end
            EXPAND: begin
                // Step s produces rk[2+2s] and rk[3+2s]; the last step has no rk[15].
                wr_hi_en   = 1'b1;
                wr_hi_idx  = {step_q, 1'b0} + 4'd2;
                wr_hi_data = next_key[KEYW-1:KEYW/2];
                wr_lo_en   = (step_q != LAST_STEP);
                wr_lo_idx  = {step_q, 1'b0} + 4'd3;
                wr_lo_data = next_key[KEYW/2-1:0];
                key_d      = next_key;
                rc_d       = xtime(rc_q);
                step_d     = step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            step_q   <= 3'd0;
            rc_q     <= 8'h01;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            rd_key_q <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            step_q   <= step_d;
            rc_q     <= rc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            rd_key_q <= (rd_addr <= 4'(NR)) ? rk_q[rd_addr] : '0;
            if (wr_hi_en) rk_q[wr_hi_idx] <= wr_hi_data;
            if (wr_lo_en) rk_q[wr_lo_idx] <= wr_lo_data;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign valid  = valid_q;
    assign rd_key = rd_key_q;

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Directed bench for the AES-256 key schedule using FIPS-197 A.3 and all-zero keys.
module tb_aes256_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         valid;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [255:0] K_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK0_A3 = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] RK1_A3 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK2_A3 = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK14_A3 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] RK2_Z  = 128'h62636363626363636263636362636363;

    aes256_key_schedule dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .rd_addr (rd_addr),
        .rd_key  (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge just after the sampling edge.
    task automatic kick(input logic [255:0] key);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [127:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_key;
    endtask

    // Back-to-back addresses 0..15, each result checked one cycle after its address.
    task automatic sweep_a3();
        logic [127:0] exp;
        @(negedge clk);
        rd_addr = 4'd0;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            case (a)
                0:  chk("sweep_rk0", rd_key, RK0_A3);
                1:  chk("sweep_rk1", rd_key, RK1_A3);
                2:  chk("sweep_rk2", rd_key, RK2_A3);
                14: chk("sweep_rk14", rd_key, RK14_A3);
                15: chk("sweep_rk15_zero", rd_key, 128'h0);
                default: begin
                    exp = 128'd1;
                    chk($sformatf("sweep_rk%0d_nonzero", a), 128'(rd_key != 128'h0), exp);
                end
            endcase
            rd_addr = 4'(a + 1);
        end
    endtask

    logic [127:0] v;
    int           cyc;
    logic         seen_done;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_rdkey", rd_key, 128'h0);
        rd(4'd7, v);
        chk("rst_rk7", v, 128'h0);
        rd(4'd15, v);
        chk("rst_rk15", v, 128'h0);
        repeat (3) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; key_in = K_A3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 128'(busy), 128'd0);
        chk("rst_start_valid", 128'(valid), 128'd0);

        // FIPS-197 A.3 single run
        kick(K_A3);
        chk("a3_busy", 128'(busy), 128'd1);
        chk("a3_valid_low", 128'(valid), 128'd0);
        wait_done(cyc);
        chk("a3_done_latency", 128'(cyc), 128'd7);
        chk("a3_valid", 128'(valid), 128'd1);
        @(negedge clk);
        chk("a3_done_pulse", 128'(done), 128'd0);
        chk("a3_valid_hold", 128'(valid), 128'd1);
        chk("a3_busy_end", 128'(busy), 128'd0);
        sweep_a3();

        // second start at k+3 with a different key is ignored
        kick(K_A3);
        repeat (2) @(negedge clk);
        start = 1'b1; key_in = '0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("dbl_done_latency", 128'(cyc), 128'd4);
        rd(4'd2, v);
        chk("dbl_rk2", v, RK2_A3);
        rd(4'd14, v);
        chk("dbl_rk14", v, RK14_A3);

        // rst sampled at k+4 aborts the schedule
        kick(K_A3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_valid", 128'(valid), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", 128'(seen_done), 128'd0);
        for (int a = 0; a < 15; a++) begin
            rd(4'(a), v);
            chk($sformatf("abort_rk%0d_zero", a), v, 128'h0);
        end
        kick(K_A3);
        wait_done(cyc);
        chk("rerun_done_latency", 128'(cyc), 128'd7);

        // start in the done cycle with the all-zero key
        start = 1'b1; key_in = '0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_valid_fall", 128'(valid), 128'd0);
        chk("b2b_done_fall", 128'(done), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        wait_done(cyc);
        chk("b2b_done_latency", 128'(cyc), 128'd7);
        rd(4'd2, v);
        chk("b2b_rk2", v, RK2_Z);
        rd(4'd1, v);
        chk("b2b_rk1", v, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
